// File: rtl/bank_line_reader_pkg.sv
// Shared definitions for the line-bank reader: FSM state encoding and default pixel width.
package bank_line_reader_pkg;

   localparam int DEFAULT_DATA_WIDTH = 24;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/line_reader_fifo.sv
// Small synchronous FIFO holding {tlast, pixel} words between the bank read port and the
// AXI-Stream output. The read side shows zero whenever the FIFO is empty.
module line_reader_fifo #(
   parameter int WIDTH       = 25,
   parameter int DEPTH       = 2,
   parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic                   valid,
   output logic [WIDTH-1:0]       pop_data,
   output logic [COUNT_WIDTH-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
   localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             full;
   logic             do_pop;

   assign valid    = (count != '0);
   assign full     = (count == FULL_COUNT);
   assign do_pop   = pop && valid;
   assign pop_data = valid ? mem[rd_ptr] : '0;

   // Pointers wrap explicitly so non-power-of-two depths work too.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + PW'(1);
         end
         case ({push, do_pop})
            2'b10:   count <= count + COUNT_WIDTH'(1);
            2'b01:   count <= count - COUNT_WIDTH'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // The reader's issue throttle guarantees room for every returning read.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(push && full));
      end
   end

endmodule

// File: rtl/bank_line_reader.sv
// Reads one line of pixels from a block-RAM line bank and streams it out on AXI-Stream,
// hiding the bank's one-cycle read latency behind a small skid FIFO.
module bank_line_reader
   import bank_line_reader_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = 32,
   parameter int LEN_WIDTH  = 12,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [LEN_WIDTH-1:0]  line_len,
   output logic                  busy,
   output logic                  done,
   output logic                  bank_cs,
   output logic                  bank_re,
   output logic [ADDR_WIDTH-1:0] bank_raddr,
   input  logic [DATA_WIDTH-1:0] bank_dout,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tlast
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);
   localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [LEN_WIDTH-1:0]  remaining;
   logic                  inflight;
   logic                  inflight_last;
   logic                  done_q;

   logic [CW-1:0]         fifo_count;
   logic                  fifo_valid;
   logic [DATA_WIDTH:0]   fifo_word;
   logic                  pop;
   logic                  issue;
   logic [CW:0]           occupancy;
   logic [CW:0]           limit;

   // A read is issued in the same cycle the room check passes, so a pop this cycle frees
   // a slot immediately and a two-entry FIFO sustains one pixel per cycle.
   assign pop       = m_axis_tvalid & m_axis_tready;
   assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
   assign limit     = DEPTH_W + {{CW{1'b0}}, pop};
   assign issue     = (state == ST_READ) && (occupancy < limit);

   assign bank_re       = issue;
   assign bank_cs       = issue;
   assign bank_raddr    = addr_q;
   assign busy          = (state != ST_IDLE);
   assign done          = done_q;
   assign m_axis_tvalid = fifo_valid;
   assign m_axis_tdata  = fifo_word[DATA_WIDTH-1:0];
   assign m_axis_tlast  = fifo_word[DATA_WIDTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         addr_q        <= '0;
         remaining     <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         done_q        <= 1'b0;
         inflight      <= issue;
         inflight_last <= issue && (remaining == LEN_ONE);
         case (state)
            ST_IDLE: begin
               if (start && (line_len != '0)) begin
                  addr_q    <= base_addr;
                  remaining <= line_len;
                  state     <= ST_READ;
               end
            end
            ST_READ: begin
               if (issue) begin
                  addr_q    <= addr_q + ADDR_WIDTH'(1);
                  remaining <= remaining - LEN_ONE;
                  if (remaining == LEN_ONE) begin
                     state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (pop && m_axis_tlast) begin
                  state  <= ST_IDLE;
                  done_q <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   line_reader_fifo #(
      .WIDTH       (DATA_WIDTH + 1),
      .DEPTH       (FIFO_DEPTH),
      .COUNT_WIDTH (CW)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight),
      .push_data ({inflight_last, bank_dout}),
      .pop       (pop),
      .valid     (fifo_valid),
      .pop_data  (fifo_word),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_bank_line_reader.sv
// Bench for bank_line_reader: a behavioural bank model feeds reads, and a queue of expected
// {tlast, pixel} words is filled at each start and drained on every output handshake.
module tb_bank_line_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] base_addr;
   logic [11:0] line_len;
   logic        busy;
   logic        done;
   logic        bank_cs;
   logic        bank_re;
   logic [31:0] bank_raddr;
   logic [23:0] bank_dout;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic [23:0] m_axis_tdata;
   logic        m_axis_tlast;

   int          total = 0;
   int          bad = 0;
   logic [24:0] exp_q[$];

   bank_line_reader dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .base_addr     (base_addr),
      .line_len      (line_len),
      .busy          (busy),
      .done          (done),
      .bank_cs       (bank_cs),
      .bank_re       (bank_re),
      .bank_raddr    (bank_raddr),
      .bank_dout     (bank_dout),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tlast  (m_axis_tlast)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] pix(input logic [31:0] a);
      return {a[7:0] ^ 8'h3C, a[15:8], a[23:16] ^ a[31:24]};
   endfunction

   // Bank model: data appears one cycle after the read enable.
   always @(posedge clk) begin
      if (bank_re) bank_dout <= pix(bank_raddr);
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic push_line(input logic [31:0] base, input int len);
      for (int i = 0; i < len; i++) begin
         exp_q.push_back({(i == len - 1), pix(base + 32'(i))});
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      base_addr = '0;
      line_len = '0;
      m_axis_tready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({busy, done, bank_cs, bank_re, m_axis_tvalid, m_axis_tlast} !== 6'b0) begin
         bad++;
         $display("[TB] FAIL reset_flags got=%b want=000000",
                  {busy, done, bank_cs, bank_re, m_axis_tvalid, m_axis_tlast});
      end
      total++;
      if (bank_raddr !== 32'h0) begin
         bad++;
         $display("[TB] FAIL reset_raddr got=%h want=00000000", bank_raddr);
      end
      total++;
      if (m_axis_tdata !== 24'h0) begin
         bad++;
         $display("[TB] FAIL reset_tdata got=%h want=000000", m_axis_tdata);
      end
      next_cycle();
      rst = 1'b0;
   endtask

   task automatic test_basic(input bit mid_start);
      logic [24:0] e;
      next_cycle();
      start = 1'b1;
      base_addr = 32'h10;
      line_len = 12'd4;
      m_axis_tready = 1'b1;
      push_line(32'h10, 4);
      for (int j = 1; j <= 9; j++) begin
         next_cycle();
         start = mid_start && (j == 2);
         base_addr = mid_start ? 32'h99 : 32'h10;
         line_len = mid_start ? 12'd7 : 12'd4;
         @(negedge clk);
         total++;
         if (bank_re !== (j >= 1 && j <= 4) || bank_cs !== bank_re) begin
            bad++;
            $display("[TB] FAIL basic_re cyc=%0d re=%b cs=%b", j, bank_re, bank_cs);
         end
         if (j >= 1 && j <= 4) begin
            total++;
            if (bank_raddr !== 32'(32'h10 + j - 1)) begin
               bad++;
               $display("[TB] FAIL basic_raddr cyc=%0d got=%h want=%h", j, bank_raddr,
                        32'(32'h10 + j - 1));
            end
         end
         total++;
         if (m_axis_tvalid !== (j >= 3 && j <= 6)) begin
            bad++;
            $display("[TB] FAIL basic_tvalid cyc=%0d got=%b", j, m_axis_tvalid);
         end
         if (m_axis_tvalid && m_axis_tready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("[TB] FAIL basic_beat unexpected got=%h", {m_axis_tlast, m_axis_tdata});
            end else begin
               e = exp_q.pop_front();
               if ({m_axis_tlast, m_axis_tdata} !== e) begin
                  bad++;
                  $display("[TB] FAIL basic_beat got=%h want=%h", {m_axis_tlast, m_axis_tdata}, e);
               end
            end
         end
         total++;
         if (done !== (j == 7)) begin
            bad++;
            $display("[TB] FAIL basic_done cyc=%0d got=%b want=%b", j, done, (j == 7));
         end
         total++;
         if (busy !== (j >= 1 && j <= 6)) begin
            bad++;
            $display("[TB] FAIL basic_busy cyc=%0d got=%b", j, busy);
         end
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("[TB] FAIL basic_left got=%0d want=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_zero_len();
      next_cycle();
      start = 1'b1;
      base_addr = 32'h123;
      line_len = 12'd0;
      for (int j = 1; j <= 5; j++) begin
         next_cycle();
         start = 1'b0;
         @(negedge clk);
         total++;
         if ({busy, bank_re, done, m_axis_tvalid} !== 4'b0) begin
            bad++;
            $display("[TB] FAIL zero_len cyc=%0d got=%b want=0000", j,
                     {busy, bank_re, done, m_axis_tvalid});
         end
      end
   endtask

   task automatic test_backpressure();
      logic [24:0] e;
      logic [24:0] prev_word = '0;
      logic        prev_stall = 1'b0;
      int          reads = 0;
      int          beats = 0;
      bit          seen = 0;
      next_cycle();
      start = 1'b1;
      base_addr = 32'h200;
      line_len = 12'd8;
      m_axis_tready = 1'b0;
      push_line(32'h200, 8);
      for (int j = 1; j <= 60 && !seen; j++) begin
         next_cycle();
         start = 1'b0;
         m_axis_tready = (j % 2 == 1);
         @(negedge clk);
         if (bank_re) reads++;
         if (prev_stall) begin
            total++;
            if (!m_axis_tvalid || {m_axis_tlast, m_axis_tdata} !== prev_word) begin
               bad++;
               $display("[TB] FAIL bp_hold cyc=%0d got=%b/%h want=1/%h", j, m_axis_tvalid,
                        {m_axis_tlast, m_axis_tdata}, prev_word);
            end
         end
         if (m_axis_tvalid && m_axis_tready) begin
            beats++;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("[TB] FAIL bp_beat unexpected got=%h", {m_axis_tlast, m_axis_tdata});
            end else begin
               e = exp_q.pop_front();
               if ({m_axis_tlast, m_axis_tdata} !== e) begin
                  bad++;
                  $display("[TB] FAIL bp_beat got=%h want=%h", {m_axis_tlast, m_axis_tdata}, e);
               end
            end
         end
         total++;
         if (reads - beats > 2) begin
            bad++;
            $display("[TB] FAIL bp_ahead cyc=%0d got=%0d want<=2", j, reads - beats);
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_word = {m_axis_tlast, m_axis_tdata};
         if (done) seen = 1;
      end
      total++;
      if (!seen || beats != 8 || reads != 8 || exp_q.size() != 0) begin
         bad++;
         $display("[TB] FAIL bp_end done=%0d beats=%0d reads=%0d left=%0d want=1/8/8/0",
                  seen, beats, reads, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_stall();
      logic [24:0] e;
      int          reads = 0;
      int          beats = 0;
      bit          seen = 0;
      next_cycle();
      start = 1'b1;
      base_addr = 32'h300;
      line_len = 12'd5;
      m_axis_tready = 1'b0;
      push_line(32'h300, 5);
      for (int j = 1; j <= 20; j++) begin
         next_cycle();
         start = 1'b0;
         @(negedge clk);
         if (bank_re) reads++;
      end
      total++;
      if (reads != 2) begin
         bad++;
         $display("[TB] FAIL stall_reads got=%0d want=2", reads);
      end
      total++;
      if (!m_axis_tvalid || {m_axis_tlast, m_axis_tdata} !== {1'b0, pix(32'h300)}) begin
         bad++;
         $display("[TB] FAIL stall_head got=%b/%h want=1/%h", m_axis_tvalid,
                  {m_axis_tlast, m_axis_tdata}, {1'b0, pix(32'h300)});
      end
      for (int j = 21; j <= 50 && !seen; j++) begin
         next_cycle();
         m_axis_tready = 1'b1;
         @(negedge clk);
         if (bank_re) reads++;
         if (m_axis_tvalid && m_axis_tready) begin
            beats++;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("[TB] FAIL stall_beat unexpected got=%h", {m_axis_tlast, m_axis_tdata});
            end else begin
               e = exp_q.pop_front();
               if ({m_axis_tlast, m_axis_tdata} !== e) begin
                  bad++;
                  $display("[TB] FAIL stall_beat got=%h want=%h", {m_axis_tlast, m_axis_tdata}, e);
               end
            end
         end
         if (done) seen = 1;
      end
      total++;
      if (!seen || reads != 5 || beats != 5) begin
         bad++;
         $display("[TB] FAIL stall_end done=%0d reads=%0d beats=%0d want=1/5/5", seen, reads, beats);
         exp_q.delete();
      end
   endtask

   task automatic test_reset_midline();
      logic [24:0] e;
      int          beats = 0;
      bit          seen = 0;
      next_cycle();
      start = 1'b1;
      base_addr = 32'h500;
      line_len = 12'd6;
      m_axis_tready = 1'b1;
      push_line(32'h500, 6);
      for (int j = 1; j <= 20 && beats < 2; j++) begin
         next_cycle();
         start = 1'b0;
         @(negedge clk);
         if (m_axis_tvalid && m_axis_tready) begin
            beats++;
            total++;
            e = exp_q.pop_front();
            if ({m_axis_tlast, m_axis_tdata} !== e) begin
               bad++;
               $display("[TB] FAIL rst_pre_beat got=%h want=%h", {m_axis_tlast, m_axis_tdata}, e);
            end
         end
      end
      next_cycle();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({busy, done, bank_cs, bank_re, m_axis_tvalid, m_axis_tlast} !== 6'b0 ||
          bank_raddr !== 32'h0 || m_axis_tdata !== 24'h0) begin
         bad++;
         $display("[TB] FAIL rst_mid_state flags=%b raddr=%h tdata=%h want=0",
                  {busy, done, bank_cs, bank_re, m_axis_tvalid, m_axis_tlast},
                  bank_raddr, m_axis_tdata);
      end
      exp_q.delete();
      beats = 0;
      next_cycle();
      start = 1'b1;
      base_addr = 32'h40;
      line_len = 12'd2;
      push_line(32'h40, 2);
      for (int j = 1; j <= 20 && !seen; j++) begin
         next_cycle();
         start = 1'b0;
         @(negedge clk);
         if (m_axis_tvalid && m_axis_tready) begin
            beats++;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("[TB] FAIL rst_new_beat unexpected got=%h", {m_axis_tlast, m_axis_tdata});
            end else begin
               e = exp_q.pop_front();
               if ({m_axis_tlast, m_axis_tdata} !== e) begin
                  bad++;
                  $display("[TB] FAIL rst_new_beat got=%h want=%h", {m_axis_tlast, m_axis_tdata}, e);
               end
            end
         end
         if (done) seen = 1;
      end
      total++;
      if (!seen || beats != 2) begin
         bad++;
         $display("[TB] FAIL rst_new_end done=%0d beats=%0d want=1/2", seen, beats);
         exp_q.delete();
      end
   endtask

   task automatic test_wrap();
      logic [24:0] e;
      logic [31:0] want_addr[3];
      logic [31:0] got_addr[$];
      bit          seen = 0;
      want_addr[0] = 32'hFFFF_FFFE;
      want_addr[1] = 32'hFFFF_FFFF;
      want_addr[2] = 32'h0000_0000;
      next_cycle();
      start = 1'b1;
      base_addr = 32'hFFFF_FFFE;
      line_len = 12'd3;
      m_axis_tready = 1'b1;
      push_line(32'hFFFF_FFFE, 3);
      for (int j = 1; j <= 20 && !seen; j++) begin
         next_cycle();
         start = 1'b0;
         @(negedge clk);
         if (bank_re) got_addr.push_back(bank_raddr);
         if (m_axis_tvalid && m_axis_tready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("[TB] FAIL wrap_beat unexpected got=%h", {m_axis_tlast, m_axis_tdata});
            end else begin
               e = exp_q.pop_front();
               if ({m_axis_tlast, m_axis_tdata} !== e) begin
                  bad++;
                  $display("[TB] FAIL wrap_beat got=%h want=%h", {m_axis_tlast, m_axis_tdata}, e);
               end
            end
         end
         if (done) seen = 1;
      end
      total++;
      if (!seen || got_addr.size() != 3) begin
         bad++;
         $display("[TB] FAIL wrap_reads done=%0d reads=%0d want=1/3", seen, got_addr.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            total++;
            if (got_addr[i] !== want_addr[i]) begin
               bad++;
               $display("[TB] FAIL wrap_addr idx=%0d got=%h want=%h", i, got_addr[i], want_addr[i]);
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      test_reset();
      test_basic(1'b0);
      test_zero_len();
      test_basic(1'b1);
      test_backpressure();
      test_stall();
      test_reset_midline();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
